mux_con_arb: RTL and testbench

MUX_CON_ARB -- requirements
Module: mux_con_arb

---
 rtl/mux_con_arb_if.sv | 25 ++
 rtl/mux_con_arb.sv | 141 ++++++++++++++
 tb/tb_mux_con_arb.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_con_arb_if.sv
// Requester-side bus of the control-byte arbiter: requests, grants, byte lanes
// and the single muxed output stream toward the control-treat stage.
interface mux_con_arb_if;
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned BYTE_W = 8;

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ*BYTE_W-1:0] din;
    logic [N_REQ-1:0]        din_en;
    logic [BYTE_W-1:0]       con_dout;
    logic                    con_dout_en;
    logic                    busy;
    logic                    err_timeout;

    modport master (
        output req, din, din_en,
        input  gnt, con_dout, con_dout_en, busy, err_timeout
    );

    modport slave (
        input  req, din, din_en,
        output gnt, con_dout, con_dout_en, busy, err_timeout
    );
endinterface

// File: rtl/mux_con_arb.sv
// Round-robin arbiter that forwards one requester frame at a time onto the
// control byte stream, with start timeout, length truncation and inter-frame gap.
module mux_con_arb #(
    parameter int unsigned GAP      = 16,
    parameter int unsigned MAX_LEN  = 256,
    parameter int unsigned START_TO = 64
) (
    input  logic          clk,
    input  logic          rst,
    mux_con_arb_if.slave  bus
);
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LEN_W  = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_XFER,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    g_idx;
    logic [IDX_W-1:0]    ptr;
    logic [CNT_W-1:0]    cnt;
    logic [LEN_W-1:0]    len;

    logic [IDX_W-1:0]    pick_idx_c;
    logic                pick_vld_c;
    logic [IDX_W-1:0]    cand_c;
    logic [BYTE_W-1:0]   sel_byte_c;
    logic                sel_en_c;

    // Round-robin pick: scanning downward lets the smallest offset from ptr win.
    always_comb begin
        pick_idx_c = '0;
        pick_vld_c = 1'b0;
        cand_c     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_c = ptr + IDX_W'(i);
            if (bus.req[cand_c]) begin
                pick_idx_c = cand_c;
                pick_vld_c = 1'b1;
            end
        end
    end

    assign sel_byte_c = bus.din[{g_idx, 3'b000} +: BYTE_W];
    assign sel_en_c   = bus.din_en[g_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            g_idx           <= '0;
            ptr             <= '0;
            cnt             <= '0;
            len             <= '0;
            bus.gnt         <= '0;
            bus.con_dout    <= '0;
            bus.con_dout_en <= 1'b0;
            bus.busy        <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.err_timeout <= 1'b0;
            bus.con_dout    <= '0;
            bus.con_dout_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld_c) begin
                        g_idx    <= pick_idx_c;
                        bus.gnt  <= N_REQ'(1) << pick_idx_c;
                        ptr      <= pick_idx_c + IDX_W'(1);
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (sel_en_c) begin
                        bus.con_dout    <= sel_byte_c;
                        bus.con_dout_en <= 1'b1;
                        len             <= LEN_W'(1);
                        state           <= S_XFER;
                    end else if (!bus.req[g_idx]) begin
                        // Requester withdrew before sending anything: no gap, no error.
                        bus.gnt  <= '0;
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end else if (cnt == CNT_W'(START_TO - 1)) begin
                        bus.err_timeout <= 1'b1;
                        bus.gnt         <= '0;
                        cnt             <= '0;
                        state           <= S_GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_XFER: begin
                    if (!sel_en_c) begin
                        bus.gnt <= '0;
                        cnt     <= '0;
                        state   <= S_GAP;
                    end else if (len == LEN_W'(MAX_LEN)) begin
                        // Byte beyond the length limit: truncate and swallow the rest.
                        bus.err_timeout <= 1'b1;
                        bus.gnt         <= '0;
                        state           <= S_DRAIN;
                    end else begin
                        bus.con_dout    <= sel_byte_c;
                        bus.con_dout_en <= 1'b1;
                        len             <= len + LEN_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (!sel_en_c) begin
                        cnt   <= '0;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt == CNT_W'(GAP - 1)) begin
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_con_arb.sv
// Directed bench for mux_con_arb: single frame, round-robin, start timeout,
// truncation, mid-frame reset and withdrawn request.
module tb_mux_con_arb;
    logic clk = 1'b0;
    logic rst;

    mux_con_arb_if bus ();

    mux_con_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] out_q[$];
    logic [7:0] exp_q[$];
    int low_run;
    int min_low;
    int err_cnt;
    bit run_started;
    bit mon_en = 1'b0;

    // Output stream monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.err_timeout) err_cnt++;
            if (bus.con_dout_en) begin
                out_q.push_back(bus.con_dout);
                if (run_started && low_run > 0 && low_run < min_low) min_low = low_run;
                low_run     = 0;
                run_started = 1'b1;
            end else begin
                low_run++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        out_q.delete();
        exp_q.delete();
        low_run     = 0;
        min_low     = 1000;
        err_cnt     = 0;
        run_started = 1'b0;
        mon_en      = 1'b1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        bus.req    = '0;
        bus.din    = '0;
        bus.din_en = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        int g;
        int bad;

        // Reset values while reset is held
        rst        = 1'b0;
        bus.req    = '0;
        bus.din    = '0;
        bus.din_en = '0;
        step();
        step();
        chk("rst_gnt",  32'(bus.gnt), 32'h0);
        chk("rst_en",   32'(bus.con_dout_en), 32'h0);
        chk("rst_dout", 32'(bus.con_dout), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_err",  32'(bus.err_timeout), 32'h0);
        rst = 1'b1;

        // Single 5-byte frame from requester 0; requester 1 chatter must be ignored
        bus.req = 4'b0001;
        step();
        chk("f1_gnt",  32'(bus.gnt), 32'h1);
        chk("f1_busy", 32'(bus.busy), 32'h1);
        for (int j = 1; j <= 5; j++) begin
            bus.din    = {16'h0, 8'hEE, 8'(j)};
            bus.din_en = 4'b0011;
            step();
            chk($sformatf("f1_byte%0d", j), 32'({bus.con_dout_en, bus.con_dout}), 32'(9'h100 | j));
        end
        bus.din_en = '0;
        bus.req    = '0;
        step();
        chk("f1_end_en",  32'(bus.con_dout_en), 32'h0);
        chk("f1_end_gnt", 32'(bus.gnt), 32'h0);
        for (int i = 0; i < 15; i++) step();
        chk("f1_gap_busy15", 32'(bus.busy), 32'h1);
        step();
        chk("f1_gap_busy16", 32'(bus.busy), 32'h0);

        // All four requesting: grant order 0,1,2,3,0 with 3-byte frames
        do_reset();
        mon_clear();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int b = 0; b < 100 && bus.gnt == 4'b0000; b++) step();
            g = k % 4;
            chk($sformatf("rr_gnt%0d", k), 32'(bus.gnt), 32'(1) << g);
            for (int j = 0; j < 3; j++) begin
                bus.din           = '0;
                bus.din[8*g +: 8] = 8'(16 * k + j + 1);
                bus.din_en        = 4'(1) << g;
                exp_q.push_back(8'(16 * k + j + 1));
                step();
            end
            bus.din_en = '0;
            if (k == 4) bus.req = '0;
            step();
            chk($sformatf("rr_drop%0d", k), 32'(bus.gnt), 32'h0);
        end
        for (int i = 0; i < 20; i++) step();
        chk("rr_count", 32'(out_q.size()), 32'd15);
        bad = 0;
        for (int i = 0; i < 15 && i < out_q.size(); i++)
            if (out_q[i] !== exp_q[i]) bad++;
        chk("rr_data", 32'(bad), 32'h0);
        chk("rr_mingap_ge16", 32'(min_low >= 16), 32'h1);

        // Start timeout on requester 2, then requester 3 after the gap
        do_reset();
        mon_clear();
        bus.req = 4'b0100;
        step();
        chk("to_gnt", 32'(bus.gnt), 32'h4);
        for (int i = 0; i < 63; i++) step();
        chk("to_pre_err", 32'(err_cnt), 32'h0);
        chk("to_pre_gnt", 32'(bus.gnt), 32'h4);
        step();
        chk("to_err",  32'(bus.err_timeout), 32'h1);
        chk("to_gnt0", 32'(bus.gnt), 32'h0);
        chk("to_busy", 32'(bus.busy), 32'h1);
        bus.req = 4'b1100;
        step();
        chk("to_err_pulse", 32'(bus.err_timeout), 32'h0);
        for (int i = 0; i < 15; i++) step();
        chk("to_gap_gnt", 32'(bus.gnt), 32'h0);
        chk("to_gap_idle", 32'(bus.busy), 32'h0);
        step();
        chk("to_next_gnt", 32'(bus.gnt), 32'h8);
        bus.req = '0;
        step();
        chk("to_withdraw_busy", 32'(bus.busy), 32'h0);

        // Requester 1 asserts req for two cycles only, no bytes
        mon_clear();
        bus.req = 4'b0010;
        step();
        chk("wd_gnt", 32'(bus.gnt), 32'h2);
        step();
        chk("wd_gnt_hold", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        step();
        chk("wd_drop_gnt", 32'(bus.gnt), 32'h0);
        chk("wd_idle", 32'(bus.busy), 32'h0);
        bus.req = 4'b0001;
        step();
        chk("wd_nogap_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        step();
        chk("wd_err_none", 32'(err_cnt), 32'h0);

        // 300-byte frame truncated at 256
        do_reset();
        mon_clear();
        bus.req = 4'b0001;
        step();
        for (int j = 0; j < 300; j++) begin
            bus.din    = {24'h0, 8'(j)};
            bus.din_en = 4'b0001;
            step();
            if (j == 255)
                chk("tr_last", 32'({bus.con_dout_en, bus.con_dout}), 32'h1FF);
            if (j == 256) begin
                chk("tr_cut_en",  32'(bus.con_dout_en), 32'h0);
                chk("tr_cut_err", 32'(bus.err_timeout), 32'h1);
                chk("tr_cut_gnt", 32'(bus.gnt), 32'h0);
            end
        end
        bus.din_en = '0;
        bus.req    = '0;
        step();
        for (int i = 0; i < 15; i++) step();
        chk("tr_gap_busy15", 32'(bus.busy), 32'h1);
        step();
        chk("tr_gap_busy16", 32'(bus.busy), 32'h0);
        chk("tr_count", 32'(out_q.size()), 32'd256);
        chk("tr_errs",  32'(err_cnt), 32'h1);
        bad = 0;
        for (int i = 0; i < out_q.size(); i++)
            if (out_q[i] !== 8'(i)) bad++;
        chk("tr_data", 32'(bad), 32'h0);

        // Asynchronous reset at byte 3 of a 10-byte frame
        mon_clear();
        bus.req = 4'b0001;
        step();
        for (int j = 1; j <= 3; j++) begin
            bus.din    = {24'h0, 8'(j)};
            bus.din_en = 4'b0001;
            step();
        end
        chk("ar_byte3", 32'({bus.con_dout_en, bus.con_dout}), 32'h103);
        rst = 1'b0;
        #1;
        chk("ar_en",   32'(bus.con_dout_en), 32'h0);
        chk("ar_gnt",  32'(bus.gnt), 32'h0);
        chk("ar_busy", 32'(bus.busy), 32'h0);
        bus.din_en = '0;
        step();
        rst = 1'b1;
        step();
        chk("ar_regnt", 32'(bus.gnt), 32'h1);
        chk("ar_regnt_en", 32'(bus.con_dout_en), 32'h0);
        bus.req = '0;
        step();
        chk("ar_idle", 32'(bus.busy), 32'h0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
